mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sequential arbiter that shares the single processor memory bus between the instruction-fetch port and the load/store data port. It sits between the datapath/controller and memory. It latches one request at a time, drives a registered bus transaction until the memory signals ready or a timeout expires, and returns a one-cycle acknowledge with read data to the requester that was granted.

## Interface
- `TIMEOUT`, default 16: maximum number of bus cycles to wait for `i_memReady` before aborting; legal range is ≥2.
- `i_clk` in 1: clock; all state changes on the rising edge.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_iReq` in 1: instruction-fetch request; held high until `o_iAck`.
- `i_iAddr` in 32: fetch address.
- `o_iAck` in/out: out 1; one-cycle fetch completion pulse.
- `o_iRData` out 32: fetched word; valid when `o_iAck`=1.
- `o_iErr` out 1: fetch timed out; valid when `o_iAck`=1.
- `i_dReq` in 1: data request; held high until `o_dAck`.
- `i_dWrite` in 1: 1 = store, 0 = load.
- `i_dAddr` in 32: data address.
- `i_dWData` in 32: store data.
- `i_dSize` in 3: access size/sign code (funct3 of the load/store).
- `o_dAck` out 1: one-cycle data completion pulse.
- `o_dRData` out 32: load data; valid when `o_dAck`=1.
- `o_dErr` out 1: data access timed out; valid when `o_dAck`=1.
- `o_memReq` out 1: bus request.
- `o_memWrite` out 1: bus write enable.
- `o_memAddr` out 32: bus address.
- `o_memWData` out 32: bus write data.
- `o_memSize` out 3: bus size code.
- `i_memReady` in 1: memory completes the current transaction this cycle.
- `i_memRData` in 32: memory read data; valid when `i_memReady`=1.
- `o_busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- FSM states and transitions:
  - IDLE: if any request is pending, perform the grant and go to BUSY.
  - BUSY: on `i_memReady`=1 or on timeout, go to RESP.
  - RESP: always go to IDLE.
- Grant on arbitration:
  - Only `i_dReq`: grant data.
  - Only `i_iReq`: grant instruction.
  - Both: grant data, unless the previous grant was data, in which case grant instruction. This is a 1-bit `lastData` register; reset value is 0.
- At grant, register the bus fields:
  - Data grant: `o_memAddr`/`o_memWData`/`o_memWrite`/`o_memSize` ← `i_dAddr`/`i_dWData`/`i_dWrite`/`i_dSize`.
  - Instruction grant: `i_iAddr`, 0, 0, 3'b010.
  - Set `o_memReq`=1.
- Bus fields stay constant for the whole BUSY period. Later changes on the request inputs are ignored.
- Wait counter:
  - Cleared at grant; increments each BUSY cycle in which `i_memReady`=0.
  - Width is $clog2(TIMEOUT)+1 bits; it never wraps.
  - Timeout = counter reaches TIMEOUT-1 while `i_memReady`=0.
- Completion on `i_memReady`=1: capture `i_memRData` into the granted port's RData register and set Err=0. For a write, RData = 0.
- Completion on timeout: RData = 0 and Err = 1.
- In both cases `o_memReq` and `o_memWrite` drop to 0 at the same edge.
- `i_memReady` and timeout in the same cycle: ready wins, Err=0.
- In RESP, only the granted port's Ack = 1. Ack, RData and Err are registered outputs.
- The requester must deassert its Req by the edge that ends its Ack cycle. The next grant is therefore evaluated in IDLE, one cycle after RESP.
- `i_memReady` is ignored outside BUSY.
- Reset (asynchronous, any state, including mid-transaction):
  - FSM → IDLE.
  - All outputs → 0.
  - `lastData`=0, counter=0.
  - The bus transaction in flight is abandoned and no Ack is produced.

## Timing
- Request sampled high at edge E0 (state IDLE).
  - From E0: `o_memReq`=1 and the bus fields are valid.
  - If `i_memReady`=1 in that first BUSY cycle, at E1 the state is RESP and Ack=1 for exactly one cycle.
- Minimum latency: request seen → Ack is 2 cycles. With k wait cycles it is 2+k.
- Maximum BUSY length is TIMEOUT cycles.
- Back-to-back throughput is at most one transaction per 3 cycles (IDLE, BUSY, RESP).
- No combinational path from any input to any output.

## Test plan
- Single fetch:
  - Stimulus: `i_iAddr`=0x100; memory ready on the first BUSY cycle with `i_memRData`=0x00500093.
  - Response: `o_memSize`=3'b010, `o_memWrite`=0, `o_iAck` 2 cycles after request with `o_iRData`=0x00500093, `o_iErr`=0.
- Store with waits:
  - Stimulus: `i_dWrite`=1, addr 0x2000, data 0xDEADBEEF, `i_dSize`=3'b001; ready after 3 wait cycles.
  - Response: bus fields stable for 4 cycles, `o_dAck` 5 cycles after request, `o_dRData`=0.
- Simultaneous requests, both held continuously:
  - Response: grant order is data, instr, data, instr. Exactly one Ack per transaction; the other Ack stays 0.
- Timeout, TIMEOUT=16, `i_memReady` held 0:
  - Response: `o_memReq` high for exactly 16 cycles, then Ack with Err=1 and RData=0.
  - Variant: ready asserted in the 16th cycle → Err=0, data captured.
- Reset mid-BUSY:
  - Stimulus: assert `i_rst_n`=0 asynchronously between edges.
  - Response: `o_memReq`, `o_busy` and all Acks go to 0 immediately; no Ack after release. The first post-reset simultaneous request grants data.
- Input change during BUSY: changing `i_dAddr`/`i_iAddr` has no effect on `o_memAddr` until the next grant.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter onto a single registered memory bus
//
// Purpose: grants one of the instruction-fetch or load/store ports at a time,
// drives a registered bus transaction until the memory reports ready or the
// wait budget runs out, then returns a one-cycle Ack with read data / error.
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_iReq/i_iAddr            fetch request and address
//   o_iAck/o_iRData/o_iErr    fetch completion pulse, data, timeout flag
//   i_dReq/i_dWrite/i_dAddr/i_dWData/i_dSize   load/store request fields
//   o_dAck/o_dRData/o_dErr    data completion pulse, load data, timeout flag
//   o_memReq/o_memWrite/o_memAddr/o_memWData/o_memSize   registered bus
//   i_memReady/i_memRData     memory completion and read data
//   o_busy                    arbiter is not idle
module mem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_iReq,
  input  logic [31:0] i_iAddr,
  output logic        o_iAck,
  output logic [31:0] o_iRData,
  output logic        o_iErr,
  input  logic        i_dReq,
  input  logic        i_dWrite,
  input  logic [31:0] i_dAddr,
  input  logic [31:0] i_dWData,
  input  logic [2:0]  i_dSize,
  output logic        o_dAck,
  output logic [31:0] o_dRData,
  output logic        o_dErr,
  output logic        o_memReq,
  output logic        o_memWrite,
  output logic [31:0] o_memAddr,
  output logic [31:0] o_memWData,
  output logic [2:0]  o_memSize,
  input  logic        i_memReady,
  input  logic [31:0] i_memRData,
  output logic        o_busy
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state;
  state_t          state_nxt;
  logic            last_data;
  logic            grant_data;
  logic [CW-1:0]   wait_cnt;
  logic            any_req;
  logic            pick_data;
  logic            timed_out;
  logic            finish;

  // Data has priority on a tie unless it won the previous arbitration.
  always_comb begin
    any_req   = i_iReq | i_dReq;
    pick_data = i_dReq & (~i_iReq | ~last_data);
    timed_out = (state == BUSY) & ~i_memReady & (wait_cnt == CNT_LAST);
    finish    = (state == BUSY) & (i_memReady | timed_out);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = BUSY;
      BUSY:    if (finish)  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_busy = (state != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_data  <= 1'b0;
      grant_data <= 1'b0;
      wait_cnt   <= '0;
      o_memReq   <= 1'b0;
      o_memWrite <= 1'b0;
      o_memAddr  <= '0;
      o_memWData <= '0;
      o_memSize  <= '0;
      o_iAck     <= 1'b0;
      o_iRData   <= '0;
      o_iErr     <= 1'b0;
      o_dAck     <= 1'b0;
      o_dRData   <= '0;
      o_dErr     <= 1'b0;
    end else begin
      o_iAck <= 1'b0;
      o_dAck <= 1'b0;
      if (state == IDLE && any_req) begin
        grant_data <= pick_data;
        last_data  <= pick_data;
        wait_cnt   <= '0;
        o_memReq   <= 1'b1;
        if (pick_data) begin
          o_memAddr  <= i_dAddr;
          o_memWData <= i_dWData;
          o_memWrite <= i_dWrite;
          o_memSize  <= i_dSize;
        end else begin
          o_memAddr  <= i_iAddr;
          o_memWData <= '0;
          o_memWrite <= 1'b0;
          o_memSize  <= 3'b010;
        end
      end else if (finish) begin
        o_memReq   <= 1'b0;
        o_memWrite <= 1'b0;
        // Ready wins over a simultaneous timeout; stores return zero data.
        if (grant_data) begin
          o_dAck   <= 1'b1;
          o_dErr   <= ~i_memReady;
          o_dRData <= (i_memReady && !o_memWrite) ? i_memRData : 32'h0;
        end else begin
          o_iAck   <= 1'b1;
          o_iErr   <= ~i_memReady;
          o_iRData <= i_memReady ? i_memRData : 32'h0;
        end
      end else if (state == BUSY) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_iReq;
  logic [31:0] i_iAddr;
  logic        o_iAck;
  logic [31:0] o_iRData;
  logic        o_iErr;
  logic        i_dReq;
  logic        i_dWrite;
  logic [31:0] i_dAddr;
  logic [31:0] i_dWData;
  logic [2:0]  i_dSize;
  logic        o_dAck;
  logic [31:0] o_dRData;
  logic        o_dErr;
  logic        o_memReq;
  logic        o_memWrite;
  logic [31:0] o_memAddr;
  logic [31:0] o_memWData;
  logic [2:0]  o_memSize;
  logic        i_memReady;
  logic [31:0] i_memRData;
  logic        o_busy;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_d;

  mem_arbiter #(.TIMEOUT(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_iReq(i_iReq), .i_iAddr(i_iAddr),
    .o_iAck(o_iAck), .o_iRData(o_iRData), .o_iErr(o_iErr),
    .i_dReq(i_dReq), .i_dWrite(i_dWrite), .i_dAddr(i_dAddr),
    .i_dWData(i_dWData), .i_dSize(i_dSize),
    .o_dAck(o_dAck), .o_dRData(o_dRData), .o_dErr(o_dErr),
    .o_memReq(o_memReq), .o_memWrite(o_memWrite), .o_memAddr(o_memAddr),
    .o_memWData(o_memWData), .o_memSize(o_memSize),
    .i_memReady(i_memReady), .i_memRData(i_memRData),
    .o_busy(o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic step();
    @(negedge i_clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    i_rst_n = 1'b0; i_iReq = 1'b0; i_iAddr = '0; i_dReq = 1'b0; i_dWrite = 1'b0;
    i_dAddr = '0; i_dWData = '0; i_dSize = '0; i_memReady = 1'b0; i_memRData = '0;
    step(); step();

    // Reset state
    chk("rst memReq", o_memReq, 0);   chk("rst memWrite", o_memWrite, 0);
    chk("rst memAddr", o_memAddr, 0); chk("rst memWData", o_memWData, 0);
    chk("rst memSize", o_memSize, 0); chk("rst busy", o_busy, 0);
    chk("rst iAck", o_iAck, 0);       chk("rst dAck", o_dAck, 0);
    chk("rst iRData", o_iRData, 0);   chk("rst dRData", o_dRData, 0);
    chk("rst iErr", o_iErr, 0);       chk("rst dErr", o_dErr, 0);
    i_rst_n = 1'b1;
    step();

    // Single fetch, ready on first BUSY cycle
    i_iReq = 1'b1; i_iAddr = 32'h100;
    step();
    chk("fetch memReq", o_memReq, 1);      chk("fetch memAddr", o_memAddr, 32'h100);
    chk("fetch memSize", o_memSize, 3'b010); chk("fetch memWrite", o_memWrite, 0);
    chk("fetch busy", o_busy, 1);          chk("fetch early iAck", o_iAck, 0);
    i_memReady = 1'b1; i_memRData = 32'h00500093;
    step();
    chk("fetch iAck", o_iAck, 1);          chk("fetch iRData", o_iRData, 32'h00500093);
    chk("fetch iErr", o_iErr, 0);          chk("fetch dAck", o_dAck, 0);
    chk("fetch memReq drop", o_memReq, 0);
    i_iReq = 1'b0; i_memReady = 1'b0; i_memRData = '0;
    step();
    chk("fetch iAck pulse", o_iAck, 0);    chk("fetch idle", o_busy, 0);

    // Store with three wait cycles
    i_dReq = 1'b1; i_dWrite = 1'b1; i_dAddr = 32'h2000; i_dWData = 32'hDEADBEEF; i_dSize = 3'b001;
    step();
    for (int k = 0; k < 4; k++) begin
      chk("store memReq", o_memReq, 1);    chk("store memWrite", o_memWrite, 1);
      chk("store memAddr", o_memAddr, 32'h2000);
      chk("store memWData", o_memWData, 32'hDEADBEEF);
      chk("store memSize", o_memSize, 3'b001);
      chk("store early dAck", o_dAck, 0);
      if (k == 3) begin i_memReady = 1'b1; i_memRData = 32'hCAFEF00D; end
      step();
    end
    chk("store dAck", o_dAck, 1);          chk("store dRData", o_dRData, 0);
    chk("store dErr", o_dErr, 0);          chk("store memReq drop", o_memReq, 0);
    chk("store memWrite drop", o_memWrite, 0);
    i_dReq = 1'b0; i_dWrite = 1'b0; i_memReady = 1'b0;
    step();
    chk("store dAck pulse", o_dAck, 0);    chk("store idle", o_busy, 0);

    // Asynchronous reset in the middle of BUSY
    i_dReq = 1'b1; i_dAddr = 32'h3000;
    step();
    chk("mid memReq", o_memReq, 1);        chk("mid busy", o_busy, 1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("async memReq", o_memReq, 0);      chk("async busy", o_busy, 0);
    chk("async memAddr", o_memAddr, 0);
    chk("async iAck", o_iAck, 0);          chk("async dAck", o_dAck, 0);
    i_dReq = 1'b0;
    step();
    i_rst_n = 1'b1; i_memReady = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("post-rst dAck", o_dAck, 0);     chk("post-rst iAck", o_iAck, 0);
      chk("post-rst busy", o_busy, 0);     chk("post-rst memReq", o_memReq, 0);
    end

    // Both requests held: data, instr, data, instr
    i_iReq = 1'b1; i_iAddr = 32'h400; i_dReq = 1'b1; i_dAddr = 32'h800; i_dWrite = 1'b0;
    for (int t = 0; t < 4; t++) begin
      exp_d = ((t % 2) == 0);
      i_memRData = 32'hA0000000 + t;
      step();
      chk("both memAddr", o_memAddr, exp_d ? 32'h800 : 32'h400);
      chk("both memReq", o_memReq, 1);
      step();
      chk("both dAck", o_dAck, {31'b0, exp_d});
      chk("both iAck", o_iAck, {31'b0, ~exp_d});
      if (exp_d) chk("both dRData", o_dRData, 32'hA0000000 + t);
      else       chk("both iRData", o_iRData, 32'hA0000000 + t);
      step();
      chk("both idle dAck", o_dAck, 0);    chk("both idle iAck", o_iAck, 0);
      chk("both idle busy", o_busy, 0);
    end
    i_iReq = 1'b0; i_dReq = 1'b0; i_memReady = 1'b0; i_memRData = '0;
    step();

    // Timeout on a fetch: memReq high for exactly 16 cycles
    i_iReq = 1'b1; i_iAddr = 32'h500;
    step();
    for (int k = 0; k < 16; k++) begin
      chk("tmo memReq", o_memReq, 1);      chk("tmo early iAck", o_iAck, 0);
      step();
    end
    chk("tmo iAck", o_iAck, 1);            chk("tmo iErr", o_iErr, 1);
    chk("tmo iRData", o_iRData, 0);        chk("tmo memReq drop", o_memReq, 0);
    i_iReq = 1'b0;
    step();
    chk("tmo iAck pulse", o_iAck, 0);

    // Ready in the 16th BUSY cycle beats the timeout
    i_dReq = 1'b1; i_dAddr = 32'h600; i_dWrite = 1'b0;
    step();
    for (int k = 0; k < 16; k++) begin
      if (k == 15) begin
        chk("late memReq", o_memReq, 1);
        i_memReady = 1'b1; i_memRData = 32'h12345678;
      end
      step();
    end
    chk("late dAck", o_dAck, 1);           chk("late dErr", o_dErr, 0);
    chk("late dRData", o_dRData, 32'h12345678);
    i_dReq = 1'b0; i_memReady = 1'b0;
    step();

    // Request inputs changing during BUSY are ignored
    i_dReq = 1'b1; i_dAddr = 32'h700; i_dWData = 32'h11; i_dWrite = 1'b1;
    step();
    chk("hold memAddr0", o_memAddr, 32'h700);
    i_dAddr = 32'h7FC; i_iAddr = 32'h9FC; i_dWData = 32'h22; i_dWrite = 1'b0;
    step();
    chk("hold memAddr1", o_memAddr, 32'h700);
    chk("hold memWData", o_memWData, 32'h11);
    chk("hold memWrite", o_memWrite, 1);
    i_memReady = 1'b1;
    step();
    chk("hold dAck", o_dAck, 1);           chk("hold memAddr2", o_memAddr, 32'h700);
    i_dReq = 1'b0; i_memReady = 1'b0;
    step();
    i_iReq = 1'b1; i_iAddr = 32'h900;
    step();
    chk("next memAddr", o_memAddr, 32'h900);
    chk("next memWData", o_memWData, 0);
    i_memReady = 1'b1; i_memRData = 32'h55;
    step();
    chk("next iAck", o_iAck, 1);           chk("next iRData", o_iRData, 32'h55);
    i_iReq = 1'b0; i_memReady = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
